color_scan_controller: RTL

// Sequences the TCS3200 colour detector and shares it between two requesters (game sequencer, debug/manual).

---
 rtl/color_scan_pkg.sv | 28 ++
 rtl/color_vote_counter.sv | 57 +++++
 rtl/color_scan_controller.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/color_scan_pkg.sv
// Shared encodings and state type for the colour scan controller and its vote counter.
// Colour codes follow the detector's 2-bit output; owner codes follow resultOwner.
package color_scan_pkg;

  localparam logic [1:0] COLOR_RED    = 2'b00;
  localparam logic [1:0] COLOR_GREEN  = 2'b01;
  localparam logic [1:0] COLOR_BLUE   = 2'b10;
  localparam logic [1:0] COLOR_YELLOW = 2'b11;

  localparam logic OWNER_GAME  = 1'b0;
  localparam logic OWNER_DEBUG = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARB       = 3'd1,
    START     = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4,
    DECIDE    = 3'd5,
    RESPOND   = 3'd6
  } state_t;

  // Round-robin: on a tie, whoever was not served last wins.
  function automatic logic rr_winner(input logic last_owner);
    return ~last_owner;
  endfunction

endpackage

// File: rtl/color_vote_counter.sv
// Four saturating per-colour vote counters with combinational majority and
// argmax (ties resolve to the lowest colour encoding).
module color_vote_counter
  import color_scan_pkg::*;
#(
  parameter int NUM_SAMPLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_inc,
  input  logic [1:0] i_color,
  output logic       o_majority,
  output logic [1:0] o_majority_color,
  output logic [1:0] o_argmax_color
);

  localparam int CW = $clog2(NUM_SAMPLES + 1);
  localparam logic [CW-1:0] HALF    = CW'(NUM_SAMPLES / 2);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [CW-1:0] r_count [4];
  logic          w_majority;
  logic [1:0]    w_majority_color;
  logic [1:0]    w_best;

  // Clear has priority over increment so a retry starts from an empty tally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) r_count[i] <= {CW{1'b0}};
    end else if (i_clear) begin
      for (int i = 0; i < 4; i++) r_count[i] <= {CW{1'b0}};
    end else if (i_inc && (r_count[i_color] != CNT_MAX)) begin
      r_count[i_color] <= r_count[i_color] + CW'(1);
    end
  end

  always_comb begin
    w_majority       = 1'b0;
    w_majority_color = COLOR_RED;
    w_best           = COLOR_RED;
    for (int i = 0; i < 4; i++) begin
      if (r_count[i] > HALF) begin
        w_majority       = 1'b1;
        w_majority_color = 2'(i);
      end else begin
        w_majority       = w_majority;
      end
      w_best = (r_count[i] > r_count[w_best]) ? 2'(i) : w_best;
    end
  end

  assign o_majority       = w_majority;
  assign o_majority_color = w_majority_color;
  assign o_argmax_color   = w_best;

endmodule

// File: rtl/color_scan_controller.sv
// Arbitrates game/debug requests for the TCS3200 detector, runs NUM_SAMPLES
// timed detections per vote set, majority-votes them and hands back one colour.
module color_scan_controller
  import color_scan_pkg::*;
#(
  parameter int NUM_SAMPLES   = 3,
  parameter int GAP_TICKS     = 1024,
  parameter int TIMEOUT_TICKS = 2**22,
  parameter int RETRY_LIMIT   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reqGame,
  input  logic       reqDebug,
  output logic       startDetection,
  input  logic       detectionComplete,
  input  logic [1:0] colorIn,
  output logic       resultValid,
  output logic [1:0] resultColor,
  output logic       resultOwner,
  output logic       resultError,
  input  logic       resultAck,
  output logic       busy
);

  localparam int SW = $clog2(NUM_SAMPLES + 1);
  localparam int TW = $clog2(TIMEOUT_TICKS);
  localparam int GW = $clog2(GAP_TICKS + 1);
  localparam int RW = (RETRY_LIMIT < 1) ? 1 : $clog2(RETRY_LIMIT + 1);

  localparam logic [SW-1:0] LAST_SAMPLE = SW'(NUM_SAMPLES - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_TICKS - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(GAP_TICKS - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(RETRY_LIMIT);

  state_t        r_state, w_next_state;
  logic          r_owner, r_last_owner;
  logic [SW-1:0] r_sample_idx;
  logic [RW-1:0] r_retry;
  logic [TW-1:0] r_tmo_cnt;
  logic [GW-1:0] r_gap_cnt;
  logic          r_start, r_valid, r_error, r_busy;
  logic [1:0]    r_color;

  logic          w_vote_clear, w_vote_inc, w_retry_inc;
  logic          w_res_load, w_res_error, w_grant_owner;
  logic [1:0]    w_res_color;
  logic          w_majority;
  logic [1:0]    w_majority_color, w_argmax_color;

  color_vote_counter #(.NUM_SAMPLES(NUM_SAMPLES)) u_vote (
    .clk              (clk),
    .reset            (reset),
    .i_clear          (w_vote_clear),
    .i_inc            (w_vote_inc),
    .i_color          (colorIn),
    .o_majority       (w_majority),
    .o_majority_color (w_majority_color),
    .o_argmax_color   (w_argmax_color)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Done beats timeout when both land in the same WAIT_DONE cycle.
  always_comb begin
    w_next_state  = r_state;
    w_vote_clear  = 1'b0;
    w_vote_inc    = 1'b0;
    w_retry_inc   = 1'b0;
    w_res_load    = 1'b0;
    w_res_error   = 1'b0;
    w_res_color   = COLOR_RED;
    w_grant_owner = r_owner;
    case (r_state)
      IDLE: begin
        if (reqGame || reqDebug) w_next_state = ARB;
        else                     w_next_state = IDLE;
      end
      ARB: begin
        w_vote_clear = 1'b1;
        if (reqGame && reqDebug) begin
          w_grant_owner = rr_winner(r_last_owner);
          w_next_state  = START;
        end else if (reqGame) begin
          w_grant_owner = OWNER_GAME;
          w_next_state  = START;
        end else if (reqDebug) begin
          w_grant_owner = OWNER_DEBUG;
          w_next_state  = START;
        end else begin
          w_next_state  = IDLE;
        end
      end
      START: w_next_state = WAIT_DONE;
      WAIT_DONE: begin
        if (detectionComplete) begin
          w_vote_inc   = 1'b1;
          w_next_state = (r_sample_idx == LAST_SAMPLE) ? DECIDE : GAP;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_res_load   = 1'b1;
          w_res_error  = 1'b1;
          w_res_color  = COLOR_RED;
          w_next_state = RESPOND;
        end else begin
          w_next_state = WAIT_DONE;
        end
      end
      GAP: w_next_state = (r_gap_cnt == GAP_LAST) ? START : GAP;
      DECIDE: begin
        if (w_majority) begin
          w_res_load   = 1'b1;
          w_res_color  = w_majority_color;
          w_next_state = RESPOND;
        end else if (r_retry < RETRY_MAX) begin
          w_retry_inc  = 1'b1;
          w_vote_clear = 1'b1;
          w_next_state = GAP;
        end else begin
          w_res_load   = 1'b1;
          w_res_error  = 1'b1;
          w_res_color  = w_argmax_color;
          w_next_state = RESPOND;
        end
      end
      RESPOND: begin
        if (resultAck) w_next_state = IDLE;
        else           w_next_state = RESPOND;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Counters, result latches and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner      <= OWNER_GAME;
      r_last_owner <= OWNER_DEBUG;
      r_sample_idx <= {SW{1'b0}};
      r_retry      <= {RW{1'b0}};
      r_tmo_cnt    <= {TW{1'b0}};
      r_gap_cnt    <= {GW{1'b0}};
      r_start      <= 1'b0;
      r_valid      <= 1'b0;
      r_error      <= 1'b0;
      r_busy       <= 1'b0;
      r_color      <= COLOR_RED;
    end else begin
      if (r_state == ARB) r_owner <= w_grant_owner;
      if ((r_state == RESPOND) && resultAck) r_last_owner <= r_owner;

      if (w_vote_clear)    r_sample_idx <= {SW{1'b0}};
      else if (w_vote_inc) r_sample_idx <= r_sample_idx + SW'(1);

      if (r_state == ARB)   r_retry <= {RW{1'b0}};
      else if (w_retry_inc) r_retry <= r_retry + RW'(1);

      if (r_state == WAIT_DONE) r_tmo_cnt <= r_tmo_cnt + TW'(1);
      else                      r_tmo_cnt <= {TW{1'b0}};

      if (r_state == GAP) r_gap_cnt <= r_gap_cnt + GW'(1);
      else                r_gap_cnt <= {GW{1'b0}};

      if (w_res_load) begin
        r_color <= w_res_color;
        r_error <= w_res_error;
      end

      r_start <= (w_next_state == START);
      r_valid <= (w_next_state == RESPOND);
      r_busy  <= (w_next_state != IDLE);
    end
  end

  assign startDetection = r_start;
  assign resultValid    = r_valid;
  assign resultColor    = r_color;
  assign resultOwner    = r_owner;
  assign resultError    = r_error;
  assign busy           = r_busy;

endmodule
